// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_ctrl_pkg                                                      |
// | Shared types, defaults and config check for trap_filter_ctrl.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package trap_ctrl_pkg;

  localparam int K_W_DEF      = 6;
  localparam int M_W_DEF      = 10;
  localparam int MAX_BUF_DEF  = 64;
  localparam int PIPE_LAT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  typedef struct packed {
    logic [K_W_DEF-1:0] k;
    logic [K_W_DEF-1:0] l;
    logic [M_W_DEF-1:0] m;
  } cfg_t;

  // Evaluated in 32-bit arithmetic so k+l can never wrap.
  function automatic logic cfg_is_valid(input int unsigned k,
                                        input int unsigned l,
                                        input int unsigned max_buf);
    return (l >= 1) && (k >= l) && ((k + l) <= (max_buf - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_ctrl_timer                                                    |
// | Loadable down-counter; done flags the final count of a phase.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module trap_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/trap_filter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_filter_ctrl                                                   |
// | Config handshake + flush/settle sequencer for the trapezoid filter.|
// | Optional saturation blanking: define TRAP_CTRL_SAT_BLANK_EN.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module trap_filter_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int K_W           = K_W_DEF,
  parameter int M_W           = M_W_DEF,
  parameter int MAX_BUF       = MAX_BUF_DEF,
  parameter int PIPE_LAT      = PIPE_LAT_DEF,
  parameter int SIZE_ADC_DATA = 12,
  parameter int SAT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [K_W-1:0]           cfg_k,
  input  logic [K_W-1:0]           cfg_l,
  input  logic [M_W-1:0]           cfg_m,
  output logic                     cfg_err,
  input  logic                     run_en,
  input  logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic [K_W-1:0]           filt_k,
  output logic [K_W-1:0]           filt_l,
  output logic [M_W-1:0]           filt_m,
  output logic                     filt_clr,
  output logic                     out_valid,
  output logic                     busy,
  output logic [SAT_W-1:0]         sat_cnt
);

  localparam int T_W = K_W + 2;

  state_t         state_q, state_d;
  logic [K_W-1:0] filt_k_q, filt_k_d, filt_l_q, filt_l_d;
  logic [M_W-1:0] filt_m_q, filt_m_d;
  logic           cfg_loaded_q, cfg_loaded_d, filt_clr_q, filt_clr_d;
  logic           cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
  logic           out_valid_q, out_valid_d, busy_q, busy_d;
  logic           accept, cfg_ok, load_new, blank_active;
  logic           ph_load, ph_done;
  logic [T_W-1:0] ph_load_val, unused_ph_cnt;

  assign accept   = cfg_valid && cfg_ready_q;
  assign cfg_ok   = cfg_is_valid(32'(cfg_k), 32'(cfg_l), MAX_BUF);
  assign load_new = accept && cfg_ok;

  always_comb begin
    state_d      = state_q;
    filt_k_d     = filt_k_q;
    filt_l_d     = filt_l_q;
    filt_m_d     = filt_m_q;
    cfg_loaded_d = cfg_loaded_q;
    cfg_err_d    = accept && !cfg_ok;
    if (load_new) begin
      filt_k_d     = cfg_k;
      filt_l_d     = cfg_l;
      filt_m_d     = cfg_m;
      cfg_loaded_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (load_new) begin
          if (run_en) state_d = FLUSH;
        end else if (!accept && run_en && cfg_loaded_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!run_en)      state_d = IDLE;
        else if (ph_done) state_d = SETTLE;
      end
      SETTLE: begin
        if (!run_en)      state_d = IDLE;
        else if (ph_done) state_d = RUN;
      end
      RUN: begin
        if (!run_en)       state_d = IDLE;
        else if (load_new) state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase
    filt_clr_d  = (state_d == IDLE) || (state_d == FLUSH);
    cfg_ready_d = (state_d == IDLE) || (state_d == RUN);
    busy_d      = (state_d == FLUSH) || (state_d == SETTLE);
    out_valid_d = (state_d == RUN) && !blank_active;
    // Phase length comes from the config that will be active after this edge.
    ph_load     = (state_d != state_q);
    ph_load_val = T_W'(filt_k_d) + T_W'(filt_l_d) +
                  ((state_d == FLUSH) ? T_W'(1) : T_W'(PIPE_LAT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      filt_k_q     <= '0;
      filt_l_q     <= '0;
      filt_m_q     <= '0;
      cfg_loaded_q <= 1'b0;
      filt_clr_q   <= 1'b1;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_k_q     <= filt_k_d;
      filt_l_q     <= filt_l_d;
      filt_m_q     <= filt_m_d;
      cfg_loaded_q <= cfg_loaded_d;
      filt_clr_q   <= filt_clr_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  trap_ctrl_timer #(.W(T_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_load_val),
    .cnt      (unused_ph_cnt),
    .done     (ph_done)
  );

`ifdef TRAP_CTRL_SAT_BLANK_EN
  logic             sat_hit, blank_load, blank_done;
  logic [T_W-1:0]   blank_cnt, blank_load_val;
  logic [SAT_W-1:0] sat_cnt_q, sat_cnt_d;

  assign sat_hit = (state_q == RUN) && ((adc_data == '1) || (adc_data == '0));
  // Reloading zero whenever RUN is left keeps a stale window out of the next run.
  assign blank_load     = sat_hit || (state_d != RUN);
  assign blank_load_val = (sat_hit && (state_d == RUN)) ?
                          (T_W'(filt_k_q) + T_W'(filt_l_q) + T_W'(PIPE_LAT)) : '0;
  assign blank_active   = sat_hit || ((blank_cnt != '0) && !blank_done);

  trap_ctrl_timer #(.W(T_W)) u_blank_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (blank_load),
    .load_val (blank_load_val),
    .cnt      (blank_cnt),
    .done     (blank_done)
  );

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (load_new) begin
      sat_cnt_d = '0;
    end else if (sat_hit && (sat_cnt_q != {SAT_W{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + SAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_adc;
  assign unused_adc   = ^adc_data;
  assign blank_active = 1'b0;
  assign sat_cnt      = '0;
`endif

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign filt_k    = filt_k_q;
  assign filt_l    = filt_l_q;
  assign filt_m    = filt_m_q;
  assign filt_clr  = filt_clr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_filter_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_trap_filter_ctrl                                                |
// | Scoreboard bench: timestamp-based reference model vs DUT outputs.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_trap_filter_ctrl;

  localparam int K_W      = 6;
  localparam int M_W      = 10;
  localparam int ADC_W    = 12;
  localparam int SAT_W    = 16;
  localparam int PIPE_LAT = 4;
  localparam int MAX_BUF  = 64;
`ifdef TRAP_CTRL_SAT_BLANK_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, cfg_valid, run_en;
  logic [K_W-1:0]   cfg_k, cfg_l;
  logic [M_W-1:0]   cfg_m;
  logic [ADC_W-1:0] adc_data;
  logic             cfg_ready, cfg_err, filt_clr, out_valid, busy;
  logic [K_W-1:0]   filt_k, filt_l;
  logic [M_W-1:0]   filt_m;
  logic [SAT_W-1:0] sat_cnt;

  trap_filter_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_k     (cfg_k),
    .cfg_l     (cfg_l),
    .cfg_m     (cfg_m),
    .cfg_err   (cfg_err),
    .run_en    (run_en),
    .adc_data  (adc_data),
    .filt_k    (filt_k),
    .filt_l    (filt_l),
    .filt_m    (filt_m),
    .filt_clr  (filt_clr),
    .out_valid (out_valid),
    .busy      (busy),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k, l, m, sat;
    bit clr, ready, err, ov, busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a shaping sequence is a start edge plus elapsed time.
  int m_k, m_l, m_m, m_sat, m_edge, m_seq_edge, m_blank_until;
  bit m_loaded, m_in_seq, m_ready, m_err;

  // 0 idle, 1 flush, 2 settle, 3 run
  function automatic int phase_of(bit in_seq, int elapsed);
    int f, s;
    f = m_k + m_l + 1;
    s = m_k + m_l + PIPE_LAT;
    if (!in_seq)            return 0;
    else if (elapsed < f)   return 1;
    else if (elapsed < f+s) return 2;
    else                    return 3;
  endfunction

  task automatic model_step();
    exp_t x;
    int   cur, nxt;
    bit   acc, ok, hit;
    m_edge++;
    cur = phase_of(m_in_seq, m_edge - 1 - m_seq_edge);
    if (reset) begin
      m_k = 0; m_l = 0; m_m = 0; m_sat = 0;
      m_loaded = 0; m_in_seq = 0; m_ready = 0; m_err = 0;
      m_blank_until = -1;
      nxt = 0;
    end else begin
      acc = cfg_valid && m_ready;
      ok  = (int'(cfg_l) >= 1) && (int'(cfg_k) >= int'(cfg_l)) &&
            (int'(cfg_k) + int'(cfg_l) <= MAX_BUF - 1);
      hit = SAT_EN && (cur == 3) && (adc_data == 12'h000 || adc_data == 12'hFFF);
      m_err = acc && !ok;
      if (acc && ok) begin
        m_k = int'(cfg_k); m_l = int'(cfg_l); m_m = int'(cfg_m);
        m_loaded = 1; m_sat = 0;
      end else if (hit && m_sat < 65535) begin
        m_sat++;
      end
      case (cur)
        0: begin
          if (acc && ok) begin
            if (run_en) begin m_in_seq = 1; m_seq_edge = m_edge; end
          end else if (!acc && run_en && m_loaded) begin
            m_in_seq = 1; m_seq_edge = m_edge;
          end
        end
        1, 2: if (!run_en) m_in_seq = 0;
        default: begin
          if (!run_en) m_in_seq = 0;
          else if (acc && ok) m_seq_edge = m_edge;
        end
      endcase
      nxt = phase_of(m_in_seq, m_edge - m_seq_edge);
      if (nxt != 3)  m_blank_until = -1;
      else if (hit) m_blank_until = m_edge + m_k + m_l + PIPE_LAT - 1;
      m_ready = (nxt == 0) || (nxt == 3);
    end
    x.k = m_k; x.l = m_l; x.m = m_m; x.sat = m_sat;
    x.err   = m_err;
    x.clr   = (nxt == 0) || (nxt == 1);
    x.ready = m_ready;
    x.busy  = (nxt == 1) || (nxt == 2);
    x.ov    = (nxt == 3) && (m_edge > m_blank_until);
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every pushed expectation is compared against the settled outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("filt_k",    32'(filt_k),    32'(x.k));
        chk("filt_l",    32'(filt_l),    32'(x.l));
        chk("filt_m",    32'(filt_m),    32'(x.m));
        chk("filt_clr",  32'(filt_clr),  32'(x.clr));
        chk("cfg_ready", 32'(cfg_ready), 32'(x.ready));
        chk("cfg_err",   32'(cfg_err),   32'(x.err));
        chk("out_valid", 32'(out_valid), 32'(x.ov));
        chk("busy",      32'(busy),      32'(x.busy));
        chk("sat_cnt",   32'(sat_cnt),   32'(x.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      adc_data = ADC_W'($urandom_range(1, 4094));
      tick();
    end
  endtask

  task automatic offer(input int k, input int l, input int m);
    cfg_valid = 1'b1;
    cfg_k = K_W'(k); cfg_l = K_W'(l); cfg_m = M_W'(m);
    adc_data = ADC_W'($urandom_range(1, 4094));
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; run_en = 1'b0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0; adc_data = 12'h001;
    m_k = 0; m_l = 0; m_m = 0; m_sat = 0; m_edge = 0; m_seq_edge = 0;
    m_loaded = 0; m_in_seq = 0; m_ready = 0; m_err = 0; m_blank_until = -1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic start-up into RUN
    run_en = 1'b1;
    offer(8, 4, 20);
    idle(35);

    // Invalid configurations while running
    offer(3, 5, 1);   idle(1);
    offer(5, 0, 2);   idle(1);
    offer(40, 30, 3); idle(1);

    // Reconfigure in RUN with cfg_valid held through FLUSH/SETTLE
    cfg_valid = 1'b1; cfg_k = 6'd16; cfg_l = 6'd8; cfg_m = 10'd99;
    idle(40);
    cfg_valid = 1'b0;
    idle(20);

    // Saturation samples 5 cycles apart
    offer(8, 4, 20);
    idle(31);
    adc_data = 12'hFFF; tick();
    idle(4);
    adc_data = 12'h000; tick();
    idle(30);

    // run_en drop mid-SETTLE, then restart with retained config
    offer(8, 4, 20);
    idle(17);
    run_en = 1'b0; tick();
    run_en = 1'b1;
    idle(35);

    // Reset mid-FLUSH: nothing loaded, run_en alone must not start
    offer(10, 5, 7);
    idle(5);
    reset = 1'b1; tick();
    reset = 1'b0;
    idle(10);
    offer(8, 4, 20);
    idle(32);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) run_en = ~run_en;
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_k     = K_W'($urandom_range(0, 40));
      cfg_l     = K_W'($urandom_range(0, 30));
      cfg_m     = M_W'($urandom);
      if ($urandom_range(0, 19) == 0)
        adc_data = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'h000;
      else
        adc_data = ADC_W'($urandom_range(1, 4094));
      tick();
    end
    reset = 1'b0; cfg_valid = 1'b0;
    idle(3);

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_filter_ctrl.md
Name: trap_filter_ctrl

Overview:
- Sequencer for the trapezoidal shaping filter: takes (k, l, M) shaping configurations over a valid/ready handshake and validates them.
- Applies a configuration atomically, holds the filter cleared while its delay line flushes, then waits for the pipeline to settle before qualifying filter output with out_valid.
- Sits between the slow-control register interface and the filter instance, one controller per ADC channel.

Parameters:
- K_W, 6, width of k and l fields
- M_W, 10, width of multiplier M field
- MAX_BUF, 64, filter delay-line depth; k+l must be <= MAX_BUF-1
- PIPE_LAT, 4, filter pipeline latency in cycles (input to output_data)
- SIZE_ADC_DATA, 12, ADC sample width
- SAT_W, 16, saturation counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_k  in  K_W  requested k
- cfg_l  in  K_W  requested l
- cfg_m  in  M_W  requested M
- cfg_err  out  1  one-cycle pulse: accepted configuration was rejected as invalid
- run_en  in  1  level: enable shaping
- adc_data  in  SIZE_ADC_DATA  raw ADC sample (used only with the optional feature)
- filt_k  out  K_W  active k to filter
- filt_l  out  K_W  active l to filter
- filt_m  out  M_W  active M to filter
- filt_clr  out  1  hold filter state cleared
- out_valid  out  1  filter output_data is valid this cycle
- busy  out  1  state is FLUSH or SETTLE
- sat_cnt  out  SAT_W  saturated-sample count

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, filt_k/l/m=0, cfg_loaded=0, filt_clr=1, cfg_ready=0, cfg_err=0, out_valid=0, busy=0, sat_cnt=0.
- Reset asserted in any state (including mid-FLUSH/SETTLE) returns to these values on the next edge.
- States:
  - IDLE: filt_clr=1, cfg_ready=1.
  - FLUSH: filt_clr=1, cfg_ready=0, busy=1.
  - SETTLE: filt_clr=0, cfg_ready=0, busy=1.
  - RUN: filt_clr=0, cfg_ready=1, out_valid=1.
- Accept means cfg_valid && cfg_ready at a clock edge.
- A configuration is valid iff all of: l>=1; k>=l; k+l<=MAX_BUF-1. Evaluate the sum at K_W+1 bits, with no wrap.
- Invalid accept:
  - cfg_err=1 for exactly the next cycle.
  - Active configuration and state are unchanged.
- Valid accept:
  - Latch into filt_k/l/m on that edge and set cfg_loaded=1.
  - In IDLE with run_en=1, or in RUN with run_en=1: go to FLUSH.
  - In IDLE with run_en=0: stay IDLE.
- IDLE->FLUSH also occurs when run_en=1 && cfg_loaded=1 and there is no accept.
- FLUSH lasts F = k+l+1 cycles, then SETTLE.
- SETTLE lasts S = k+l+PIPE_LAT cycles, then RUN.
- Latency: accept at edge N puts FLUSH in cycles N+1..N+F. out_valid first goes high in cycle N+1+F+S.
- run_en=0 in FLUSH, SETTLE or RUN: go to IDLE on the next edge, with out_valid=0 and filt_clr=1 in that cycle.
- Simultaneous accept and run_en=0 in RUN: a valid configuration is latched, state goes IDLE, and a later run_en=1 triggers FLUSH.
- filt_k/l/m change only on a valid accept edge, never mid-FLUSH/SETTLE. cfg_ready=0 there prevents it.
- The phase timer is a loadable down-counter (width K_W+2) loaded on state entry; the state advances when the count reaches 1.

Optional Feature:
- Macro: TRAP_CTRL_SAT_BLANK_EN.
- Defined:
  - In RUN, an adc_data sample equal to all-ones or all-zeros counts as saturated.
  - Each saturated sample increments sat_cnt, saturating at 2^SAT_W-1; sat_cnt clears on reset or a valid accept.
  - Each saturated sample forces out_valid=0 for the next k+l+PIPE_LAT cycles. The blanking window retriggers: each further saturated sample restarts it.
  - Leaving RUN clears the blanking window.
- Not defined: adc_data is ignored, sat_cnt is constant 0, no blanking logic is synthesised.

Decomposition:
- Shared package trap_ctrl_pkg:
  - state enum typedef (IDLE, FLUSH, SETTLE, RUN)
  - cfg struct typedef {k, l, m}
  - K_W, M_W, MAX_BUF, PIPE_LAT defaults
  - config-valid function
- One sub-module, trap_ctrl_timer: loadable down-counter with load, load_val and done outputs. It is instanced for the phase timer and, when the macro is defined, for the blanking timer.

Test Plan:
- Reset, then accept k=8, l=4, M=20 with run_en=1 at edge N -> filt_clr=1 for cycles N+1..N+13, SETTLE for 16 cycles, out_valid=1 from cycle N+30, filt_k=8, filt_l=4, filt_m=20.
- Invalid configs k=3,l=5 / l=0 / k=40,l=30 -> cfg_err one-cycle pulse each; filt_* and state unchanged; a subsequent valid config is still accepted.
- In RUN, accept k=16, l=8 -> out_valid drops the next cycle, FLUSH 25 cycles, SETTLE 28 cycles, RUN resumes; cfg_valid held during FLUSH/SETTLE sees cfg_ready=0.
- run_en=0 mid-SETTLE -> IDLE next edge with filt_clr=1; run_en=1 again -> full FLUSH restart using the retained configuration. Reset mid-FLUSH -> all reset values, cfg_loaded=0, and run_en=1 alone does not start FLUSH.
- Macro defined, k=8, l=4, RUN: adc_data=0xFFF for one cycle -> sat_cnt=1, out_valid=0 for 16 cycles; a second saturated sample 5 cycles later -> sat_cnt=2, window restarts (21 cycles low in total).
- Macro undefined, same stimulus -> sat_cnt=0, out_valid stays 1.
